// File: rtl/game_stats_tracker.sv
// -----------------------------------------------------------------------------
// game_stats_tracker
//   Per-game statistics engine: lives, score, collected-fruit mask, post-hit
//   invulnerability, extra lives at score thresholds, game-over / win states and
//   a frame-stable BCD copy of the score for the HUD.
//
// Ports
//   clk, resetN        system clock, asynchronous active-low reset
//   startOfFrame       one-cycle pulse per video frame
//   newGame            synchronous restart (same effect as reset, top priority)
//   coll_monster       player/monster collision level
//   coll_fruit         per-fruit collision levels
//   lives, score       current lives / binary score
//   score_bcd          BCD score, digit 0 in bits [3:0], updated once per frame
//   fruit_mask         sticky collected flags, fruit_count = popcount(fruit_mask)
//   invulnerable, game_over, win   state flags
//   hit_pulse, fruit_pulse         one-cycle event pulses
// -----------------------------------------------------------------------------
module game_stats_tracker #(
    parameter int NUM_FRUITS       = 10,
    parameter int START_LIVES      = 3,
    parameter int MAX_LIVES        = 7,
    parameter int SCORE_DIGITS     = 3,
    parameter int FRUIT_POINTS     = 2,
    parameter int HIT_PENALTY      = 5,
    parameter int EXTRA_LIFE_EVERY = 20,
    parameter int INVULN_FRAMES    = 60,
    localparam int LIVES_W   = $clog2(MAX_LIVES + 1),
    localparam int SCORE_MAX = 10 ** SCORE_DIGITS - 1,
    localparam int SCORE_W   = $clog2(SCORE_MAX + 1),
    localparam int FC_W      = $clog2(NUM_FRUITS + 1)
) (
    input  logic                      clk,
    input  logic                      resetN,
    input  logic                      startOfFrame,
    input  logic                      newGame,
    input  logic                      coll_monster,
    input  logic [NUM_FRUITS-1:0]     coll_fruit,
    output logic [LIVES_W-1:0]        lives,
    output logic [SCORE_W-1:0]        score,
    output logic [4*SCORE_DIGITS-1:0] score_bcd,
    output logic [NUM_FRUITS-1:0]     fruit_mask,
    output logic [FC_W-1:0]           fruit_count,
    output logic                      invulnerable,
    output logic                      game_over,
    output logic                      win,
    output logic                      hit_pulse,
    output logic                      fruit_pulse
);
    localparam int BCD_W   = 4 * SCORE_DIGITS;
    localparam int BONUS_W = $clog2(SCORE_MAX + EXTRA_LIFE_EVERY + 1);
    localparam int INV_W   = $clog2(INVULN_FRAMES + 1);
    localparam int CNT_W   = $clog2(SCORE_W + 1);
    localparam logic [NUM_FRUITS-1:0] ALL_FRUITS = {NUM_FRUITS{1'b1}};

    typedef enum logic [1:0] {
        S_PLAY   = 2'd0,
        S_INVULN = 2'd1,
        S_OVER   = 2'd2,
        S_WIN    = 2'd3
    } state_t;

    function automatic logic [FC_W-1:0] popcount(input logic [NUM_FRUITS-1:0] v);
        logic [FC_W-1:0] acc;
        acc = {FC_W{1'b0}};
        for (int i = 0; i < NUM_FRUITS; i++) begin
            acc = acc + FC_W'(v[i]);
        end
        return acc;
    endfunction

    // Double-dabble correction: add 3 to every BCD digit that is 5 or more.
    function automatic logic [BCD_W-1:0] dabble_adj(input logic [BCD_W-1:0] b);
        logic [BCD_W-1:0] r;
        r = b;
        for (int i = 0; i < SCORE_DIGITS; i++) begin
            if (r[4*i +: 4] >= 4'd5) begin
                r[4*i +: 4] = r[4*i +: 4] + 4'd3;
            end else begin
                r[4*i +: 4] = r[4*i +: 4];
            end
        end
        return r;
    endfunction

    state_t                 state_q, state_d;
    logic [LIVES_W-1:0]     lives_q, lives_d;
    logic [SCORE_W-1:0]     score_q, score_d;
    logic [NUM_FRUITS-1:0]  fruit_mask_q, fruit_mask_d;
    logic [FC_W-1:0]        fruit_count_q, fruit_count_d;
    logic [BONUS_W-1:0]     next_bonus_q, next_bonus_d;
    logic [INV_W-1:0]       inv_cnt_q, inv_cnt_d;
    logic                   invuln_q, over_q, win_q, hit_pulse_q, fruit_pulse_q;

    logic                   active_s, hit_s, last_life_s, award_s;
    logic [NUM_FRUITS-1:0]  new_fruit_s;
    logic [31:0]            raw_sum_s, penalty_s;

    logic                   conv_busy_q;
    logic [CNT_W-1:0]       conv_cnt_q;
    logic [SCORE_W-1:0]     conv_bin_q;
    logic [BCD_W-1:0]       conv_bcd_q, conv_adj_s, score_bcd_q;

    assign active_s   = (state_q == S_PLAY) || (state_q == S_INVULN);
    assign conv_adj_s = dabble_adj(conv_bcd_q);

    // Next-state computation for score, lives, fruit mask, bonus threshold and FSM.
    always_comb begin
        new_fruit_s   = active_s ? (coll_fruit & ~fruit_mask_q) : {NUM_FRUITS{1'b0}};
        hit_s         = (state_q == S_PLAY) && coll_monster;
        last_life_s   = hit_s && (lives_q == LIVES_W'(1));
        fruit_mask_d  = fruit_mask_q | new_fruit_s;
        fruit_count_d = popcount(fruit_mask_d);

        // Gain and penalty are combined first so the clamp happens in one step.
        raw_sum_s = 32'(score_q) + 32'(FRUIT_POINTS) * 32'(popcount(new_fruit_s));
        penalty_s = hit_s ? 32'(HIT_PENALTY) : 32'd0;
        if (raw_sum_s < penalty_s) begin
            score_d = {SCORE_W{1'b0}};
        end else if ((raw_sum_s - penalty_s) > 32'(SCORE_MAX)) begin
            score_d = SCORE_W'(SCORE_MAX);
        end else begin
            score_d = SCORE_W'(raw_sum_s - penalty_s);
        end

        // A losing hit is final, so it blocks any award in the same cycle.
        award_s = active_s && !last_life_s && (32'(score_d) >= 32'(next_bonus_q));
        if (award_s) begin
            next_bonus_d = next_bonus_q + BONUS_W'(EXTRA_LIFE_EVERY);
        end else begin
            next_bonus_d = next_bonus_q;
        end

        if (last_life_s) begin
            lives_d = {LIVES_W{1'b0}};
        end else if (hit_s && award_s) begin
            lives_d = lives_q;
        end else if (hit_s) begin
            lives_d = lives_q - LIVES_W'(1);
        end else if (award_s && (lives_q != LIVES_W'(MAX_LIVES))) begin
            lives_d = lives_q + LIVES_W'(1);
        end else begin
            lives_d = lives_q;
        end

        if (hit_s && !last_life_s) begin
            inv_cnt_d = INV_W'(INVULN_FRAMES);
        end else if ((state_q == S_INVULN) && startOfFrame && (inv_cnt_q != {INV_W{1'b0}})) begin
            inv_cnt_d = inv_cnt_q - INV_W'(1);
        end else begin
            inv_cnt_d = inv_cnt_q;
        end

        case (state_q)
            S_PLAY: begin
                if (last_life_s) begin
                    state_d = S_OVER;
                end else if (fruit_mask_d == ALL_FRUITS) begin
                    state_d = S_WIN;
                end else if (hit_s) begin
                    state_d = S_INVULN;
                end else begin
                    state_d = S_PLAY;
                end
            end
            S_INVULN: begin
                if (fruit_mask_d == ALL_FRUITS) begin
                    state_d = S_WIN;
                end else if (startOfFrame && (inv_cnt_q == INV_W'(1))) begin
                    state_d = S_PLAY;
                end else begin
                    state_d = S_INVULN;
                end
            end
            S_OVER:  state_d = S_OVER;
            S_WIN:   state_d = S_WIN;
            default: state_d = S_PLAY;
        endcase
    end

    // Game state registers and registered flags/pulses; newGame restarts synchronously.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q       <= S_PLAY;
            lives_q       <= LIVES_W'(START_LIVES);
            score_q       <= {SCORE_W{1'b0}};
            fruit_mask_q  <= {NUM_FRUITS{1'b0}};
            fruit_count_q <= {FC_W{1'b0}};
            next_bonus_q  <= BONUS_W'(EXTRA_LIFE_EVERY);
            inv_cnt_q     <= {INV_W{1'b0}};
            invuln_q      <= 1'b0;
            over_q        <= 1'b0;
            win_q         <= 1'b0;
            hit_pulse_q   <= 1'b0;
            fruit_pulse_q <= 1'b0;
        end else if (newGame) begin
            state_q       <= S_PLAY;
            lives_q       <= LIVES_W'(START_LIVES);
            score_q       <= {SCORE_W{1'b0}};
            fruit_mask_q  <= {NUM_FRUITS{1'b0}};
            fruit_count_q <= {FC_W{1'b0}};
            next_bonus_q  <= BONUS_W'(EXTRA_LIFE_EVERY);
            inv_cnt_q     <= {INV_W{1'b0}};
            invuln_q      <= 1'b0;
            over_q        <= 1'b0;
            win_q         <= 1'b0;
            hit_pulse_q   <= 1'b0;
            fruit_pulse_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            lives_q       <= lives_d;
            score_q       <= score_d;
            fruit_mask_q  <= fruit_mask_d;
            fruit_count_q <= fruit_count_d;
            next_bonus_q  <= next_bonus_d;
            inv_cnt_q     <= inv_cnt_d;
            invuln_q      <= (state_d == S_INVULN);
            over_q        <= (state_d == S_OVER);
            win_q         <= (state_d == S_WIN);
            hit_pulse_q   <= hit_s;
            fruit_pulse_q <= |new_fruit_s;
        end
    end

    // Sequential binary-to-BCD conversion of the score snapshot taken at frame start.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            conv_busy_q <= 1'b0;
            conv_cnt_q  <= {CNT_W{1'b0}};
            conv_bin_q  <= {SCORE_W{1'b0}};
            conv_bcd_q  <= {BCD_W{1'b0}};
            score_bcd_q <= {BCD_W{1'b0}};
        end else if (newGame) begin
            conv_busy_q <= 1'b0;
            conv_cnt_q  <= {CNT_W{1'b0}};
            conv_bin_q  <= {SCORE_W{1'b0}};
            conv_bcd_q  <= {BCD_W{1'b0}};
            score_bcd_q <= {BCD_W{1'b0}};
        end else if (!conv_busy_q) begin
            if (startOfFrame) begin
                conv_busy_q <= 1'b1;
                conv_cnt_q  <= CNT_W'(SCORE_W);
                conv_bin_q  <= score_q;
                conv_bcd_q  <= {BCD_W{1'b0}};
            end
        end else if (conv_cnt_q != {CNT_W{1'b0}}) begin
            conv_bcd_q <= (conv_adj_s << 1'b1) | {{(BCD_W-1){1'b0}}, conv_bin_q[SCORE_W-1]};
            conv_bin_q <= conv_bin_q << 1'b1;
            conv_cnt_q <= conv_cnt_q - CNT_W'(1);
        end else begin
            // Publish only once all bits are shifted in, so the HUD never sees partials.
            score_bcd_q <= conv_bcd_q;
            conv_busy_q <= 1'b0;
        end
    end

    assign lives        = lives_q;
    assign score        = score_q;
    assign score_bcd    = score_bcd_q;
    assign fruit_mask   = fruit_mask_q;
    assign fruit_count  = fruit_count_q;
    assign invulnerable = invuln_q;
    assign game_over    = over_q;
    assign win          = win_q;
    assign hit_pulse    = hit_pulse_q;
    assign fruit_pulse  = fruit_pulse_q;

endmodule

// File: tb/tb_game_stats_tracker.sv
module tb_game_stats_tracker;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        resetN, sof, new_game, coll_monster;
    logic [9:0]  coll_fruit;
    logic [2:0]  lives;
    logic [9:0]  score;
    logic [11:0] score_bcd;
    logic [9:0]  fruit_mask;
    logic [3:0]  fruit_count;
    logic        invulnerable, game_over, win, hit_pulse, fruit_pulse;

    logic        sof2, new_game2, coll_monster2;
    logic [15:0] coll_fruit2;
    logic [2:0]  lives2;
    logic [6:0]  score2;
    logic [7:0]  score_bcd2;
    logic [15:0] fruit_mask2;
    logic [4:0]  fruit_count2;
    logic        invulnerable2, game_over2, win2, hit_pulse2, fruit_pulse2;

    int checks = 0;
    int errors = 0;
    int hits, fps;

    game_stats_tracker u_dut (
        .clk(clk), .resetN(resetN), .startOfFrame(sof), .newGame(new_game),
        .coll_monster(coll_monster), .coll_fruit(coll_fruit),
        .lives(lives), .score(score), .score_bcd(score_bcd), .fruit_mask(fruit_mask),
        .fruit_count(fruit_count), .invulnerable(invulnerable), .game_over(game_over),
        .win(win), .hit_pulse(hit_pulse), .fruit_pulse(fruit_pulse)
    );

    game_stats_tracker #(.NUM_FRUITS(16), .SCORE_DIGITS(2), .FRUIT_POINTS(7), .START_LIVES(5)) u_dut2 (
        .clk(clk), .resetN(resetN), .startOfFrame(sof2), .newGame(new_game2),
        .coll_monster(coll_monster2), .coll_fruit(coll_fruit2),
        .lives(lives2), .score(score2), .score_bcd(score_bcd2), .fruit_mask(fruit_mask2),
        .fruit_count(fruit_count2), .invulnerable(invulnerable2), .game_over(game_over2),
        .win(win2), .hit_pulse(hit_pulse2), .fruit_pulse(fruit_pulse2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        resetN = 1'b0;
        repeat (2) tick();
        checks++; if (lives !== 3'd3) begin errors++; $display("FAIL reset_lives: got %0d expected 3", lives); end
        checks++; if (score !== 10'd0 || score_bcd !== 12'h000) begin errors++; $display("FAIL reset_score: got %0d/%h expected 0/000", score, score_bcd); end
        checks++; if (fruit_mask !== 10'h000 || fruit_count !== 4'd0) begin errors++; $display("FAIL reset_mask: got %h/%0d expected 000/0", fruit_mask, fruit_count); end
        checks++; if ({invulnerable, game_over, win, hit_pulse, fruit_pulse} !== 5'b00000) begin errors++; $display("FAIL reset_flags: got %b expected 00000", {invulnerable, game_over, win, hit_pulse, fruit_pulse}); end
        resetN = 1'b1;
        tick();
        checks++; if (lives !== 3'd3 || score !== 10'd0) begin errors++; $display("FAIL post_reset: got lives %0d score %0d expected 3/0", lives, score); end
    endtask

    task automatic test_fruit_hold();
        fps = 0;
        coll_fruit = 10'h010;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (fruit_pulse) fps++;
        end
        coll_fruit = 10'h000;
        checks++; if (fps !== 1) begin errors++; $display("FAIL hold_pulses: got %0d expected 1", fps); end
        checks++; if (score !== 10'd2) begin errors++; $display("FAIL hold_score: got %0d expected 2", score); end
        checks++; if (fruit_mask !== 10'h010 || fruit_count !== 4'd1) begin errors++; $display("FAIL hold_mask: got %h/%0d expected 010/1", fruit_mask, fruit_count); end
        sof = 1'b1; tick(); sof = 1'b0;
        repeat (10) tick();
        checks++; if (score_bcd !== 12'h000) begin errors++; $display("FAIL bcd_early: got %h expected 000", score_bcd); end
        tick();
        checks++; if (score_bcd !== 12'h002) begin errors++; $display("FAIL bcd_value: got %h expected 002", score_bcd); end
    endtask

    task automatic test_multi_fruit();
        coll_fruit = 10'h007; tick(); coll_fruit = 10'h000;
        checks++; if (score !== 10'd8 || fruit_count !== 4'd4) begin errors++; $display("FAIL multi: got score %0d count %0d expected 8/4", score, fruit_count); end
        checks++; if (fruit_pulse !== 1'b1) begin errors++; $display("FAIL multi_pulse: got %b expected 1", fruit_pulse); end
    endtask

    task automatic test_hit_invuln();
        hits = 0;
        coll_monster = 1'b1;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (hit_pulse) hits++;
        end
        checks++; if (hits !== 1) begin errors++; $display("FAIL hit_count: got %0d expected 1", hits); end
        checks++; if (lives !== 3'd2 || score !== 10'd3) begin errors++; $display("FAIL hit_vals: got lives %0d score %0d expected 2/3", lives, score); end
        checks++; if (invulnerable !== 1'b1) begin errors++; $display("FAIL invuln_on: got %b expected 1", invulnerable); end
        for (int i = 0; i < 59; i++) begin
            sof = 1'b1; tick(); sof = 1'b0;
            if (hit_pulse) hits++;
            tick();
            if (hit_pulse) hits++;
        end
        checks++; if (invulnerable !== 1'b1 || hits !== 1) begin errors++; $display("FAIL invuln_59: got inv %b hits %0d expected 1/1", invulnerable, hits); end
        sof = 1'b1; tick(); sof = 1'b0;
        checks++; if (invulnerable !== 1'b0 || hit_pulse !== 1'b0) begin errors++; $display("FAIL invuln_60: got inv %b hit %b expected 0/0", invulnerable, hit_pulse); end
        tick();
        checks++; if (hit_pulse !== 1'b1 || lives !== 3'd1 || score !== 10'd0) begin errors++; $display("FAIL second_hit: got hit %b lives %0d score %0d expected 1/1/0", hit_pulse, lives, score); end
        checks++; if (invulnerable !== 1'b1) begin errors++; $display("FAIL reinvuln: got %b expected 1", invulnerable); end
        coll_monster = 1'b0;
        for (int i = 0; i < 60; i++) begin
            sof = 1'b1; tick(); sof = 1'b0;
            tick();
        end
        checks++; if (invulnerable !== 1'b0) begin errors++; $display("FAIL invuln_expire: got %b expected 0", invulnerable); end
    endtask

    task automatic test_game_over();
        coll_monster = 1'b1; coll_fruit = 10'h008; tick();
        checks++; if (lives !== 3'd0 || game_over !== 1'b1) begin errors++; $display("FAIL over: got lives %0d over %b expected 0/1", lives, game_over); end
        checks++; if (score !== 10'd0 || fruit_mask !== 10'h01F || hit_pulse !== 1'b1) begin errors++; $display("FAIL over_vals: got score %0d mask %h hit %b expected 0/01F/1", score, fruit_mask, hit_pulse); end
        hits = 0; fps = 0;
        coll_fruit = 10'h3FF;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (hit_pulse) hits++;
            if (fruit_pulse) fps++;
        end
        checks++; if (hits !== 0 || fps !== 0 || lives !== 3'd0 || score !== 10'd0 || fruit_mask !== 10'h01F || win !== 1'b0) begin
            errors++; $display("FAIL over_frozen: got hits %0d fps %0d lives %0d score %0d mask %h win %b expected 0/0/0/0/01F/0", hits, fps, lives, score, fruit_mask, win);
        end
        new_game = 1'b1; tick();
        new_game = 1'b0; coll_monster = 1'b0; coll_fruit = 10'h000;
        checks++; if (lives !== 3'd3 || score !== 10'd0 || fruit_mask !== 10'h000 || fruit_count !== 4'd0) begin errors++; $display("FAIL newgame: got lives %0d score %0d mask %h count %0d expected 3/0/000/0", lives, score, fruit_mask, fruit_count); end
        checks++; if (game_over !== 1'b0 || invulnerable !== 1'b0 || hit_pulse !== 1'b0) begin errors++; $display("FAIL newgame_flags: got over %b inv %b hit %b expected 0/0/0", game_over, invulnerable, hit_pulse); end
    endtask

    task automatic test_award_win();
        coll_fruit = 10'h3FC; tick(); coll_fruit = 10'h000;
        checks++; if (score !== 10'd16 || lives !== 3'd3 || fruit_count !== 4'd8) begin errors++; $display("FAIL pre_award: got score %0d lives %0d count %0d expected 16/3/8", score, lives, fruit_count); end
        coll_fruit = 10'h003; tick(); coll_fruit = 10'h000;
        checks++; if (score !== 10'd20 || lives !== 3'd4) begin errors++; $display("FAIL award: got score %0d lives %0d expected 20/4", score, lives); end
        checks++; if (win !== 1'b1 || game_over !== 1'b0 || fruit_count !== 4'd10) begin errors++; $display("FAIL win: got win %b over %b count %0d expected 1/0/10", win, game_over, fruit_count); end
        hits = 0;
        coll_monster = 1'b1; coll_fruit = 10'h3FF;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (hit_pulse) hits++;
        end
        coll_monster = 1'b0; coll_fruit = 10'h000;
        checks++; if (hits !== 0 || lives !== 3'd4 || score !== 10'd20 || win !== 1'b1) begin errors++; $display("FAIL win_frozen: got hits %0d lives %0d score %0d win %b expected 0/4/20/1", hits, lives, score, win); end
    endtask

    task automatic test_reset_mid_bcd();
        sof = 1'b1; tick(); sof = 1'b0;
        repeat (11) tick();
        checks++; if (score_bcd !== 12'h020) begin errors++; $display("FAIL bcd_20: got %h expected 020", score_bcd); end
        sof = 1'b1; tick(); sof = 1'b0;
        repeat (3) tick();
        resetN = 1'b0;
        #1;
        checks++; if (score_bcd !== 12'h000 || lives !== 3'd3 || score !== 10'd0) begin errors++; $display("FAIL async_reset: got bcd %h lives %0d score %0d expected 000/3/0", score_bcd, lives, score); end
        checks++; if (win !== 1'b0 || fruit_mask !== 10'h000) begin errors++; $display("FAIL async_reset_flags: got win %b mask %h expected 0/000", win, fruit_mask); end
        #3;
        resetN = 1'b1;
        repeat (2) tick();
    endtask

    task automatic test_saturate_param();
        coll_fruit2 = 16'h7FFF; tick(); coll_fruit2 = 16'h0000;
        checks++; if (score2 !== 7'd99 || lives2 !== 3'd6) begin errors++; $display("FAIL sat_score: got score %0d lives %0d expected 99/6", score2, lives2); end
        repeat (4) tick();
        checks++; if (lives2 !== 3'd7 || win2 !== 1'b0) begin errors++; $display("FAIL sat_lives_cap: got lives %0d win %b expected 7/0", lives2, win2); end
        sof2 = 1'b1; tick(); sof2 = 1'b0;
        repeat (8) tick();
        checks++; if (score_bcd2 !== 8'h99) begin errors++; $display("FAIL sat_bcd: got %h expected 99", score_bcd2); end
    endtask

    initial begin
        resetN = 1'b0; sof = 1'b0; new_game = 1'b0; coll_monster = 1'b0; coll_fruit = 10'h000;
        sof2 = 1'b0; new_game2 = 1'b0; coll_monster2 = 1'b0; coll_fruit2 = 16'h0000;
        test_reset();
        test_fruit_hold();
        test_multi_fruit();
        test_hit_invuln();
        test_game_over();
        test_award_win();
        test_reset_mid_bcd();
        test_saturate_param();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
